ram_scan_bist: RTL

Parametrised RAM scan / built-in self-test engine that writes a selectable data pattern across a RAM address range and reads it back, comparing every word. It sits beside the CPU's data RAM and takes over the RAM address, data and strobe lines while busy, replacing program-driven RAM scans. It adds inverted-address, checkerboard and March C- modes, first-failure capture, an error counter and abort.

---
 rtl/ram_scan_bist.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_scan_bist.sv
// RAM scan / built-in self-test engine: drives a RAM through fill/verify or March C- sequences,
// compares every read word and records the first failure plus a saturating error count.
module ram_scan_bist #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LAST_ADDR  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  _mr,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  stop_on_fail,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  _ram_we,
    output logic                  _ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_MARCH, S_DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                      input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        case (m)
            2'd0: v = DATA_WIDTH'(a);
            2'd1: v = ~DATA_WIDTH'(a);
            2'd2: for (int i = 0; i < DATA_WIDTH; i++) v[i] = a[0] ? (i % 2 == 1) : (i % 2 == 0);
            default: v = '0;
        endcase
        return v;
    endfunction

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic                  sof_q, sof_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;
    logic                  pass_q, pass_d;

    logic                  busy_w, mismatch, elem_up, at_end;
    logic [DATA_WIDTH-1:0] cur_exp;

    assign busy_w = (state_q == S_FILL) || (state_q == S_VERIFY) || (state_q == S_MARCH);

    // Expected word of the read now on the bus: P(a) in VERIFY, O for M2/M4 reads, Z otherwise.
    assign cur_exp  = (state_q == S_VERIFY) ? pattern(mode_q, addr_q)
                    : ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : ZERO;
    assign mismatch = busy_w && !oe_n_q && (ram_rdata != cur_exp);
    assign elem_up  = !((elem_q == 3'd3) || (elem_q == 3'd4));
    assign at_end   = elem_up ? (addr_q == LAST) : (addr_q == '0);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        sof_d       = sof_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_n_d      = we_n_q;
        oe_n_d      = oe_n_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        pass_d      = pass_q;

        if (!busy_w) begin
            if (start) begin
                mode_d      = mode;
                sof_d       = stop_on_fail;
                elem_d      = '0;
                addr_d      = '0;
                we_n_d      = 1'b0;
                oe_n_d      = 1'b1;
                err_d       = '0;
                fail_addr_d = '0;
                fail_exp_d  = '0;
                fail_act_d  = '0;
                pass_d      = 1'b0;
                state_d     = (mode == 2'd3) ? S_MARCH : S_FILL;
                wdata_d     = (mode == 2'd3) ? ZERO : pattern(mode, '0);
            end
        end else begin
            if (mismatch) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                if (err_q == '0) begin
                    fail_addr_d = addr_q;
                    fail_exp_d  = cur_exp;
                    fail_act_d  = ram_rdata;
                end
            end

            case (state_q)
                S_FILL: begin
                    if (addr_q == LAST) begin
                        state_d = S_VERIFY;
                        addr_d  = '0;
                        we_n_d  = 1'b1;
                        oe_n_d  = 1'b0;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        wdata_d = pattern(mode_q, addr_q + 1'b1);
                    end
                end
                S_VERIFY: begin
                    if ((mismatch && sof_q) || (addr_q == LAST)) state_d = S_DONE;
                    else                                         addr_d  = addr_q + 1'b1;
                end
                default: begin
                    if (mismatch && sof_q) begin
                        state_d = S_DONE;
                    end else if (!oe_n_q && (elem_q != 3'd5)) begin
                        // Read half of a read-write element; write the same address next.
                        we_n_d  = 1'b0;
                        oe_n_d  = 1'b1;
                        wdata_d = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ONES : ZERO;
                    end else if (at_end) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DONE;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST : '0;
                            we_n_d = 1'b1;
                            oe_n_d = 1'b0;
                        end
                    end else begin
                        addr_d = elem_up ? addr_q + 1'b1 : addr_q - 1'b1;
                        we_n_d = (elem_q != 3'd0);
                        oe_n_d = (elem_q == 3'd0);
                    end
                end
            endcase

            if (state_d == S_DONE) begin
                we_n_d = 1'b1;
                oe_n_d = 1'b1;
                pass_d = (err_d == '0);
            end

            if (abort) begin
                state_d     = S_IDLE;
                we_n_d      = 1'b1;
                oe_n_d      = 1'b1;
                pass_d      = 1'b0;
                err_d       = err_q;
                fail_addr_d = fail_addr_q;
                fail_exp_d  = fail_exp_q;
                fail_act_d  = fail_act_q;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            sof_q       <= 1'b0;
            elem_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sof_q       <= sof_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            pass_q      <= pass_d;
        end
    end

    assign busy          = busy_w;
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign error_count   = err_q;
    assign fail_addr     = fail_addr_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;
    assign ram_addr      = addr_q;
    assign ram_wdata     = wdata_q;
    assign _ram_we       = we_n_q;
    assign _ram_oe       = oe_n_q;

endmodule
